regfile_debug_port: RTL and testbench
=====================================

# regfile_debug_port

Debug read port for the pipeline register file. Accepts single-register or full-dump read requests over a valid/ready host interface, drives a dedicated synchronous register-file read port, and returns each value on a valid/ready response channel. Returned values are coherent with writeback: a write in flight during the read is bypassed into the response. It sits beside the decode-stage register file and gives benches and on-chip debug logic architectural register state without hierarchical probing.

## Interface
- XLEN, 32, data width
- NREG, 32, number of architectural registers (16 for RV32E); addresses at or above NREG are errors

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- dbg_req_valid  in  1  host request valid
- dbg_req_ready  out  1  block can accept a request
- dbg_req_addr  in  5  register index for a single read
- dbg_req_dump  in  1  1 = dump x1..x(NREG-1); dbg_req_addr ignored
- dbg_rsp_valid  out  1  response valid
- dbg_rsp_ready  in  1  host accepts response
- dbg_rsp_data  out  XLEN  register value
- dbg_rsp_idx  out  5  register index of this response
- dbg_rsp_err  out  1  index out of range; data forced to 0
- dbg_rsp_last  out  1  final beat of a request (1 for single reads)
- rf_rd_en  out  1  register-file debug read enable
- rf_rd_addr  out  5  register-file debug read address
- rf_rd_data  in  XLEN  read data, valid one cycle after rf_rd_en
- wb_we  in  1  writeback write enable (RegWriteW)
- wb_addr  in  5  writeback destination (WriteRegW)
- wb_data  in  XLEN  writeback data (ResultW)

## Operation
- FSM states: IDLE, READ, WAIT, RESP.
- IDLE: dbg_req_ready=1. On valid&ready, capture addr (or 1 if dump) and the dump flag; go to READ.
- READ: rf_rd_en=1, rf_rd_addr=current index; go to WAIT.
- WAIT: capture response data from rf_rd_data, or from bypass; go to RESP.
- RESP: dbg_rsp_valid=1, outputs stable until dbg_rsp_ready. On handshake: single read or last dump beat goes to IDLE; otherwise increment index and go to READ.
- Bypass: if wb_we=1 and wb_addr equals the current index in the READ or WAIT cycle, the response carries wb_data; if both cycles hit, the WAIT-cycle value wins. Writes during RESP do not alter a pending response.
- Index 0: data 0, no bypass, rf_rd_en still pulses, same latency as other indices.
- Index >= NREG: dbg_rsp_err=1, data 0, rf_rd_en stays 0, same latency.
- Dump: indices 1..NREG-1 in ascending order, dbg_rsp_last=1 only on index NREG-1; never errors.
- The block never writes the register file and never stalls the pipeline.

## Timing
- Reset (rst=0, asynchronous): state IDLE. dbg_req_ready=1 after release; dbg_rsp_valid, dbg_rsp_data, dbg_rsp_idx, dbg_rsp_err, dbg_rsp_last, rf_rd_en, rf_rd_addr all 0. Reset mid-request abandons the request with no response.
- Request accepted at edge T: rf_rd_en high in cycle T+1, data captured at T+2 edge, dbg_rsp_valid high from T+3.
- Best-case single-read turnaround is 4 cycles, handshake to handshake. The response handshake cycle returns the FSM to IDLE, so dbg_req_ready is high in the following cycle.
- Dump beats: one beat per 3 cycles with dbg_rsp_ready held high. Backpressure stretches RESP indefinitely without losing data.
- dbg_req_ready=0 in every non-IDLE state. Requests are not queued.
- dbg_rsp_* are registered outputs. None depend combinationally on dbg_rsp_ready.

## Test plan
- x2 holds 120, request addr=2 -> after 3 cycles dbg_rsp_valid=1, data=0x78, idx=2, last=1, err=0.
- Request addr=5 while wb_we=1, wb_addr=5, wb_data=0xDEADBEEF coincides with the READ cycle; the register file still holds 8 -> response data=0xDEADBEEF.
- Request addr=0 with wb_we=1, wb_addr=0, wb_data=0xFFFFFFFF -> data=0, err=0.
- dump=1 with x_i=i*4 and dbg_rsp_ready toggling 1,0,1,0 -> 31 beats, idx 1..31 in order, data i*4, last only on idx 31, no beat dropped or repeated.
- NREG=16, request addr=20 -> err=1, data=0, rf_rd_en never asserted. Then a dump -> 15 beats, last on idx 15.
- Assert rst low during WAIT of addr=3 -> all outputs 0 immediately. After release, dbg_req_ready=1 and no stale response appears. A new request for addr=3 completes normally.

Source files
------------

// File: rtl/regfile_debug_port.sv
// Debug read port for the pipeline register file: single or dump reads over valid/ready,
// with writeback bypass so responses match architectural state at capture time.
module regfile_debug_port #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dbg_req_valid,
    output logic            dbg_req_ready,
    input  logic [4:0]      dbg_req_addr,
    input  logic            dbg_req_dump,
    output logic            dbg_rsp_valid,
    input  logic            dbg_rsp_ready,
    output logic [XLEN-1:0] dbg_rsp_data,
    output logic [4:0]      dbg_rsp_idx,
    output logic            dbg_rsp_err,
    output logic            dbg_rsp_last,
    output logic            rf_rd_en,
    output logic [4:0]      rf_rd_addr,
    input  logic [XLEN-1:0] rf_rd_data,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data
);
    typedef enum logic [1:0] {IDLE, READ, WAIT, RESP} state_t;

    localparam logic [5:0] NREG_LIM = 6'(NREG);
    localparam logic [4:0] LAST_IDX = 5'(NREG - 1);

    state_t          state, state_nxt;
    logic [4:0]      idx;
    logic            dump;
    logic            in_range;
    logic            last_beat;
    logic            wb_hit;
    logic            byp_hit;
    logic [XLEN-1:0] byp_data;

    assign in_range  = {1'b0, idx} < NREG_LIM;
    assign last_beat = !dump || (idx == LAST_IDX);
    // x0 is hardwired to zero, so a write aimed at it must never be bypassed
    assign wb_hit    = wb_we && (wb_addr == idx) && (idx != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        dbg_req_ready = 1'b0;
        rf_rd_en      = 1'b0;
        rf_rd_addr    = '0;
        case (state)
            IDLE: begin
                dbg_req_ready = 1'b1;
                if (dbg_req_valid) state_nxt = READ;
            end
            READ: begin
                rf_rd_en   = in_range;
                rf_rd_addr = idx;
                state_nxt  = WAIT;
            end
            WAIT: state_nxt = RESP;
            RESP: begin
                if (dbg_rsp_ready) state_nxt = last_beat ? IDLE : READ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx           <= '0;
            dump          <= 1'b0;
            byp_hit       <= 1'b0;
            byp_data      <= '0;
            dbg_rsp_valid <= 1'b0;
            dbg_rsp_data  <= '0;
            dbg_rsp_idx   <= '0;
            dbg_rsp_err   <= 1'b0;
            dbg_rsp_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dbg_req_valid) begin
                        idx  <= dbg_req_dump ? 5'd1 : dbg_req_addr;
                        dump <= dbg_req_dump;
                    end
                end
                READ: begin
                    byp_hit  <= wb_hit;
                    byp_data <= wb_data;
                end
                WAIT: begin
                    dbg_rsp_valid <= 1'b1;
                    dbg_rsp_idx   <= idx;
                    dbg_rsp_err   <= !in_range;
                    dbg_rsp_last  <= last_beat;
                    // WAIT-cycle write is newest, then READ-cycle write, then the array
                    if (!in_range || idx == '0) dbg_rsp_data <= '0;
                    else if (wb_hit)            dbg_rsp_data <= wb_data;
                    else if (byp_hit)           dbg_rsp_data <= byp_data;
                    else                        dbg_rsp_data <= rf_rd_data;
                end
                RESP: begin
                    if (dbg_rsp_ready) begin
                        dbg_rsp_valid <= 1'b0;
                        if (!last_beat) idx <= idx + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_debug_port.sv
// Bench for regfile_debug_port: two instances (NREG=32 and NREG=16), each with a register-file
// environment, an architectural-state model and a per-cycle compare, plus directed literal checks.
module tb_regfile_debug_port;
    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int inst, input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL inst%0d %s: got 0x%0h expected 0x%0h", inst, nm, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int NR = (g == 0) ? 32 : 16;

        logic        rst;
        logic        req_valid, req_ready, req_dump;
        logic [4:0]  req_addr;
        logic        rsp_valid, rsp_ready, rsp_err, rsp_last;
        logic [31:0] rsp_data;
        logic [4:0]  rsp_idx;
        logic        rd_en;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;

        regfile_debug_port #(.XLEN(32), .NREG(NR)) u_dut (
            .clk(clk), .rst(rst),
            .dbg_req_valid(req_valid), .dbg_req_ready(req_ready),
            .dbg_req_addr(req_addr), .dbg_req_dump(req_dump),
            .dbg_rsp_valid(rsp_valid), .dbg_rsp_ready(rsp_ready),
            .dbg_rsp_data(rsp_data), .dbg_rsp_idx(rsp_idx),
            .dbg_rsp_err(rsp_err), .dbg_rsp_last(rsp_last),
            .rf_rd_en(rd_en), .rf_rd_addr(rd_addr), .rf_rd_data(rd_data),
            .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
        );

        // register file: synchronous read, read-before-write, x0 never written
        logic [31:0] mem [32];
        always @(posedge clk) begin
            if (rd_en) rd_data <= mem[rd_addr];
            if (wb_we && wb_addr != 5'd0) mem[wb_addr] <= wb_data;
        end

        // model: a response carries the architectural value at capture time,
        // three cycles after acceptance / after the previous beat's handshake
        logic [31:0] arch [32];
        bit          m_busy = 1'b0;
        int          m_age  = 0;
        int          q[$];
        logic [31:0] m_data = '0;
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                m_busy = 1'b0;
                m_age  = 0;
                q.delete();
            end else begin
                if (wb_we && wb_addr != 5'd0) arch[wb_addr] = wb_data;
                if (!m_busy) begin
                    if (req_valid) begin
                        q.delete();
                        if (req_dump) for (int i = 1; i < NR; i++) q.push_back(i);
                        else q.push_back(int'(req_addr));
                        m_busy = 1'b1;
                        m_age  = 0;
                    end
                end else if (m_age < 2) begin
                    m_age++;
                    if (m_age == 2) m_data = (q[0] == 0 || q[0] >= NR) ? 32'd0 : arch[q[0]];
                end else if (rsp_ready) begin
                    void'(q.pop_front());
                    if (q.size() == 0) m_busy = 1'b0;
                    else m_age = 0;
                end
            end
        end

        // response-ready driver: 0 always 1, 1 toggle, 2 random, 3 always 0
        int rdy_mode = 0;
        initial begin
            rsp_ready = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                case (rdy_mode)
                    0:       rsp_ready = 1'b1;
                    1:       rsp_ready = !rsp_ready;
                    2:       rsp_ready = 1'($urandom_range(0, 1));
                    default: rsp_ready = 1'b0;
                endcase
            end
        end

        int          hs_cnt = 0, last_cnt = 0, rden_cnt = 0, seq_next = 1;
        logic [4:0]  hs_idx = '0;
        bit          seq_on = 1'b0;
        always @(negedge clk) begin : cmp
            bit exp_v, exp_rd;
            if (rst) begin
                exp_v  = m_busy && m_age == 2;
                exp_rd = m_busy && m_age == 0 && q[0] < NR;
                chk(g, "req_ready", 32'(req_ready), 32'(!m_busy));
                chk(g, "rsp_valid", 32'(rsp_valid), 32'(exp_v));
                if (exp_v) begin
                    chk(g, "rsp_data", rsp_data, m_data);
                    chk(g, "rsp_idx",  32'(rsp_idx), 32'(q[0]));
                    chk(g, "rsp_err",  32'(rsp_err), 32'(q[0] >= NR));
                    chk(g, "rsp_last", 32'(rsp_last), 32'(q.size() == 1));
                end
                chk(g, "rf_rd_en", 32'(rd_en), 32'(exp_rd));
                if (exp_rd) chk(g, "rf_rd_addr", 32'(rd_addr), 32'(q[0]));
                if (!seq_on) seq_next = 1;
                if (rsp_valid && rsp_ready) begin
                    hs_cnt++;
                    hs_idx = rsp_idx;
                    if (rsp_last) last_cnt++;
                    if (seq_on) begin
                        chk(g, "dump_seq_idx", 32'(rsp_idx), 32'(seq_next));
                        chk(g, "dump_seq_data", rsp_data, 32'(seq_next * 4));
                        seq_next++;
                    end
                end
                if (rd_en) rden_cnt++;
            end
        end

        task automatic cycle(input bit rnd);
            @(negedge clk);
            if (rnd) begin
                wb_we   = 1'($urandom_range(0, 1));
                wb_addr = 5'($urandom_range(0, 31));
                wb_data = $urandom;
            end else begin
                wb_we = 1'b0;
            end
        endtask

        task automatic send(input logic [4:0] a, input bit d, input bit rnd);
            int n = 0;
            cycle(rnd);
            req_valid = 1'b1;
            req_addr  = a;
            req_dump  = d;
            while (!req_ready && n < 500) begin
                cycle(rnd);
                n++;
            end
            chk(g, "req_accept", 32'(req_ready), 32'd1);
            cycle(rnd);
            req_valid = 1'b0;
            req_dump  = 1'b0;
            req_addr  = 5'($urandom_range(0, 31));
        endtask

        task automatic wait_idle(input bit rnd);
            int n = 0;
            do begin
                cycle(rnd);
                n++;
            end while (!req_ready && n < 3000);
            chk(g, "wait_idle", 32'(req_ready), 32'd1);
        endtask

        task automatic wb_write(input logic [4:0] a, input logic [31:0] v);
            @(negedge clk);
            wb_we   = 1'b1;
            wb_addr = a;
            wb_data = v;
        endtask

        task automatic chk_rsp(input string nm, input logic [31:0] d, input logic [4:0] i, input bit e);
            chk(g, {nm, ".valid"}, 32'(rsp_valid), 32'd1);
            chk(g, {nm, ".data"}, rsp_data, d);
            chk(g, {nm, ".idx"}, 32'(rsp_idx), 32'(i));
            chk(g, {nm, ".err"}, 32'(rsp_err), 32'(e));
            chk(g, {nm, ".last"}, 32'(rsp_last), 32'd1);
        endtask

        task automatic chk_zero(input string nm);
            chk(g, {nm, ".valid"}, 32'(rsp_valid), 32'd0);
            chk(g, {nm, ".data"}, rsp_data, 32'd0);
            chk(g, {nm, ".idx"}, 32'(rsp_idx), 32'd0);
            chk(g, {nm, ".err"}, 32'(rsp_err), 32'd0);
            chk(g, {nm, ".last"}, 32'(rsp_last), 32'd0);
            chk(g, {nm, ".rd_en"}, 32'(rd_en), 32'd0);
            chk(g, {nm, ".rd_addr"}, 32'(rd_addr), 32'd0);
        endtask

        initial begin
            int h0, l0, r0;
            rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_dump = 1'b0;
            wb_we = 1'b0; wb_addr = '0; wb_data = '0;
            repeat (3) @(negedge clk);
            chk_zero("reset");
            rst = 1'b1;

            for (int i = 1; i < 32; i++) wb_write(5'(i), 32'(i * 4));
            cycle(0);

            // dump with toggling backpressure; addr is ignored
            rdy_mode = 1; seq_on = 1'b1; h0 = hs_cnt; l0 = last_cnt;
            send(5'd7, 1'b1, 1'b0);
            wait_idle(0);
            seq_on = 1'b0;
            chk(g, "dump_beats", 32'(hs_cnt - h0), 32'(NR - 1));
            chk(g, "dump_last_cnt", 32'(last_cnt - l0), 32'd1);
            chk(g, "dump_last_idx", 32'(hs_idx), 32'(NR - 1));
            rdy_mode = 0;

            // x2 = 120: response visible three cycles after acceptance
            wb_write(5'd2, 32'd120); cycle(0);
            send(5'd2, 1'b0, 1'b0);
            chk(g, "lat_t1", 32'(rsp_valid), 32'd0);
            cycle(0);
            chk(g, "lat_t2", 32'(rsp_valid), 32'd0);
            cycle(0);
            chk_rsp("x2", 32'h78, 5'd2, 1'b0);
            cycle(0);
            chk(g, "turnaround_ready", 32'(req_ready), 32'd1);

            // write in the READ cycle is bypassed
            wb_write(5'd5, 32'd8); cycle(0);
            send(5'd5, 1'b0, 1'b0);
            wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
            cycle(0); cycle(0);
            chk_rsp("byp_read", 32'hDEADBEEF, 5'd5, 1'b0);
            wait_idle(0);

            // writes in both READ and WAIT: the later one wins
            send(5'd6, 1'b0, 1'b0);
            wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'h111;
            cycle(0);
            wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'h222;
            cycle(0);
            chk_rsp("byp_wait", 32'h222, 5'd6, 1'b0);
            wait_idle(0);

            // write during a stalled RESP leaves the pending response alone
            rdy_mode = 3;
            send(5'd7, 1'b0, 1'b0);
            cycle(0); cycle(0);
            wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hAAAA;
            cycle(0); cycle(0);
            chk_rsp("resp_hold", 32'd28, 5'd7, 1'b0);
            rdy_mode = 0;
            wait_idle(0);

            // x0 reads zero even with a write aimed at it, and still pulses rf_rd_en
            r0 = rden_cnt;
            send(5'd0, 1'b0, 1'b0);
            wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
            cycle(0); cycle(0);
            chk_rsp("x0", 32'd0, 5'd0, 1'b0);
            wait_idle(0);
            chk(g, "x0_rden", 32'(rden_cnt - r0), 32'd1);

            // index 20: error on the 16-register instance, normal read otherwise
            wb_write(5'd20, 32'h1234); cycle(0);
            r0 = rden_cnt;
            send(5'd20, 1'b0, 1'b0);
            cycle(0); cycle(0);
            chk_rsp("idx20", (NR > 20) ? 32'h1234 : 32'd0, 5'd20, NR <= 20);
            wait_idle(0);
            chk(g, "idx20_rden", 32'(rden_cnt - r0), 32'(NR > 20));

            for (int it = 0; it < 40; it++) begin
                rdy_mode = $urandom_range(0, 2);
                send(5'($urandom_range(0, 31)), $urandom_range(0, 5) == 0, 1'b1);
                wait_idle(1);
            end
            rdy_mode = 0;
            cycle(0);

            // reset during WAIT abandons the request
            wb_write(5'd3, 32'h3333); cycle(0);
            send(5'd3, 1'b0, 1'b0);
            cycle(0);
            #2 rst = 1'b0;
            #1 chk_zero("mid_reset");
            @(negedge clk); @(negedge clk);
            rst = 1'b1;
            cycle(0);
            chk(g, "post_reset_ready", 32'(req_ready), 32'd1);
            repeat (3) cycle(0);
            chk(g, "no_stale_rsp", 32'(rsp_valid), 32'd0);
            send(5'd3, 1'b0, 1'b0);
            cycle(0); cycle(0);
            chk_rsp("after_reset", 32'h3333, 5'd3, 1'b0);
            wait_idle(0);

            done_cnt++;
        end
    end

    initial begin
        for (int t = 0; t < 50000 && done_cnt < 2; t++) #10;
        if (done_cnt < 2) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d finished instances expected 2", done_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
